// File: rtl/s953_pkg.sv
// Shared definitions for the s953 handshake sequencer: one-hot state encoding,
// default timing parameters and the counter-width helper.
package s953_pkg;

  typedef enum logic [5:0] {
    IDLE    = 6'b000000,
    RT_REQ  = 6'b000001,
    RT_XFER = 6'b000010,
    BM_REQ  = 6'b000100,
    BM_XFER = 6'b001000,
    DRAIN   = 6'b010000,
    ERR     = 6'b100000
  } state_e;

  // Plain vector so that illegal encodings stay representable and recoverable.
  typedef logic [5:0] state_t;

  localparam int BURST_DEF = 4;
  localparam int TMO_DEF   = 15;

  function automatic int width_for(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int BEAT_W = width_for(BURST_DEF);
  localparam int TMO_W  = width_for(TMO_DEF);

endpackage

// File: rtl/s953_hs_timer.sv
// Small up-counter with synchronous clear, count enable and a compare-to-limit flag;
// used both as the REQ timeout counter and as the burst beat counter.
module s953_hs_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_count <= '0;
    else if (i_load) r_count <= '0;
    else if (i_en)   r_count <= r_count + 1'b1;
  end

  assign o_expire = (r_count == i_limit);

endmodule

// File: rtl/s953_hs_sequencer.sv
// Registered handshake sequencer owning State_5..State_0: runs the Rt and Bm
// two-ready handshakes, emits per-beat acks, a wrapping beat total and a sticky timeout flag.
module s953_hs_sequencer
  import s953_pkg::*;
#(
  parameter int BURST = BURST_DEF,
  parameter int TMO   = TMO_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             want_rt,
  input  logic             rdy1_rt,
  input  logic             rdy2_rt,
  input  logic             want_bm,
  input  logic             rdy1_bm,
  input  logic             rdy2_bm,
  input  logic             full_i,
  input  logic             full_o,
  input  logic             in_done,
  input  logic [2:0]       prog,
  output logic [5:0]       state,
  output logic             ack_rt,
  output logic             ack_bm,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             err
);

  localparam int BW = width_for(BURST);
  localparam int TW = width_for(TMO);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TMO);

  state_t             r_state;
  logic               r_ack_rt;
  logic               r_ack_bm;
  logic [CNT_W-1:0]   r_xfer_cnt;
  logic               r_err;

  state_t w_next;
  logic   w_beat_rt;
  logic   w_beat_bm;
  logic   w_tmo_en;
  logic   w_tmo_load;
  logic   w_tmo_exp;
  logic   w_beat_load;
  logic   w_beat_last;
  logic   w_unused;

  assign w_unused = prog[1];

  // Both counters are held clear outside the states that use them, so each REQ
  // entry starts its timeout at zero and each XFER entry starts at beat zero.
  assign w_tmo_load  = (r_state != RT_REQ) && (r_state != BM_REQ);
  assign w_beat_load = (r_state != RT_XFER) && (r_state != BM_XFER);

  s953_hs_timer #(.W(TW)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_tmo_load),
    .i_en     (w_tmo_en),
    .i_limit  (TMO_LIM),
    .o_expire (w_tmo_exp)
  );

  s953_hs_timer #(.W(BW)) u_beat (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_beat_load),
    .i_en     (w_beat_rt | w_beat_bm),
    .i_limit  (BEAT_LAST),
    .o_expire (w_beat_last)
  );

  always_comb begin
    w_next    = r_state;
    w_beat_rt = 1'b0;
    w_beat_bm = 1'b0;
    w_tmo_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (want_rt && !full_i && !full_o) w_next = RT_REQ;
        else if (want_bm && !full_o)       w_next = BM_REQ;
      end
      RT_REQ: begin
        if (!want_rt)                w_next = IDLE;
        else if (rdy1_rt && rdy2_rt) w_next = RT_XFER;
        else if (w_tmo_exp)          w_next = ERR;
        else                         w_tmo_en = 1'b1;
      end
      RT_XFER: begin
        w_beat_rt = !full_i;
        // in_done terminates the transfer even when full_i blocks the beat.
        if ((w_beat_rt && w_beat_last) || in_done) w_next = prog[2] ? DRAIN : IDLE;
      end
      BM_REQ: begin
        if (!want_bm)                w_next = IDLE;
        else if (rdy1_bm && rdy2_bm) w_next = BM_XFER;
        else if (w_tmo_exp)          w_next = ERR;
        else                         w_tmo_en = 1'b1;
      end
      BM_XFER: begin
        w_beat_bm = !full_o;
        if (w_beat_bm && w_beat_last) w_next = IDLE;
      end
      DRAIN: begin
        if (!full_i && !full_o) w_next = IDLE;
      end
      ERR: begin
        if (prog[0] && !want_rt && !want_bm) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ack_rt   <= 1'b0;
      r_ack_bm   <= 1'b0;
      r_xfer_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ack_rt <= w_beat_rt;
      r_ack_bm <= w_beat_bm;
      if (w_beat_rt || w_beat_bm) r_xfer_cnt <= r_xfer_cnt + 1'b1;
      if (w_next == ERR)                          r_err <= 1'b1;
      else if (r_state == ERR && w_next == IDLE)  r_err <= 1'b0;
    end
  end

  assign state    = r_state;
  assign ack_rt   = r_ack_rt;
  assign ack_bm   = r_ack_bm;
  assign xfer_cnt = r_xfer_cnt;
  assign err      = r_err;

endmodule

// File: tb/tb_s953_hs_sequencer.sv
// Self-checking bench for s953_hs_sequencer: per-cycle vector table through a scoreboard
// queue, plus a hand-written illegal-state recovery sequence.
module tb_s953_hs_sequencer;

  logic       clk;
  logic       rst_n;
  logic       want_rt, rdy1_rt, rdy2_rt;
  logic       want_bm, rdy1_bm, rdy2_bm;
  logic       full_i, full_o, in_done;
  logic [2:0] prog;

  logic [5:0] state, state2;
  logic       ack_rt, ack_bm, ack_rt2, ack_bm2;
  logic [7:0] xfer_cnt;
  logic [1:0] xfer_cnt2;
  logic       err, err2;

  int checks = 0;
  int errors = 0;

  // in = {rst_n, want_rt, want_bm, rdy1_rt, rdy2_rt, rdy1_bm, rdy2_bm, full_i, full_o, in_done, prog[2:0]}
  typedef struct {
    string       name;
    logic [12:0] in;
    logic [5:0]  st;
    logic        ack_rt;
    logic        ack_bm;
    logic [7:0]  cnt;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];

  s953_hs_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .want_rt(want_rt), .rdy1_rt(rdy1_rt), .rdy2_rt(rdy2_rt),
    .want_bm(want_bm), .rdy1_bm(rdy1_bm), .rdy2_bm(rdy2_bm),
    .full_i(full_i), .full_o(full_o), .in_done(in_done), .prog(prog),
    .state(state), .ack_rt(ack_rt), .ack_bm(ack_bm), .xfer_cnt(xfer_cnt), .err(err)
  );

  s953_hs_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .want_rt(want_rt), .rdy1_rt(rdy1_rt), .rdy2_rt(rdy2_rt),
    .want_bm(want_bm), .rdy1_bm(rdy1_bm), .rdy2_bm(rdy2_bm),
    .full_i(full_i), .full_o(full_o), .in_done(in_done), .prog(prog),
    .state(state2), .ack_rt(ack_rt2), .ack_bm(ack_bm2), .xfer_cnt(xfer_cnt2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add(input string nm, input logic [12:0] in, input logic [5:0] st,
                     input logic art, input logic abm, input logic [7:0] cnt, input logic e);
    vec_t v;
    v.name = nm; v.in = in; v.st = st; v.ack_rt = art; v.ack_bm = abm; v.cnt = cnt; v.err = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t v;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty actual=0 required=1");
    end else begin
      v = sbq.pop_front();
      chk({v.name, ".state"},  {2'b00, state},      {2'b00, v.st});
      chk({v.name, ".ack_rt"}, {7'd0, ack_rt},      {7'd0, v.ack_rt});
      chk({v.name, ".ack_bm"}, {7'd0, ack_bm},      {7'd0, v.ack_bm});
      chk({v.name, ".cnt"},    xfer_cnt,            v.cnt);
      chk({v.name, ".err"},    {7'd0, err},         {7'd0, v.err});
      chk({v.name, ".cnt2"},   {6'd0, xfer_cnt2},   {6'd0, v.cnt[1:0]});
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    {rst_n, want_rt, want_bm, rdy1_rt, rdy2_rt, rdy1_bm, rdy2_bm,
     full_i, full_o, in_done, prog} = v.in;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    {rst_n, want_rt, want_bm, rdy1_rt, rdy2_rt, rdy1_bm, rdy2_bm,
     full_i, full_o, in_done, prog} = 13'b0;

    // Reset with every other input high.
    for (int i = 0; i < 3; i++) add("reset", 13'b0_11_1111_11_1_111, 6'b000000, 0, 0, 8'd0, 0);

    // Rt burst: handshake completes on the second REQ cycle, four acks, back to IDLE.
    add("rt_req",   13'b1_10_0000_00_0_000, 6'b000001, 0, 0, 8'd0, 0);
    add("rt_wait",  13'b1_10_0000_00_0_000, 6'b000001, 0, 0, 8'd0, 0);
    add("rt_hs",    13'b1_10_1100_00_0_000, 6'b000010, 0, 0, 8'd0, 0);
    add("rt_b1",    13'b1_00_0000_00_0_000, 6'b000010, 1, 0, 8'd1, 0);
    add("rt_b2",    13'b1_00_0000_00_0_000, 6'b000010, 1, 0, 8'd2, 0);
    add("rt_b3",    13'b1_00_0000_00_0_000, 6'b000010, 1, 0, 8'd3, 0);
    add("rt_b4",    13'b1_00_0000_00_0_000, 6'b000000, 1, 0, 8'd4, 0);
    add("rt_idle",  13'b1_00_0000_00_0_000, 6'b000000, 0, 0, 8'd4, 0);

    // Tie goes to Rt, full_i stalls three cycles, in_done on beat 2 with drain.
    add("tie_rst",  13'b0_00_0000_00_0_000, 6'b000000, 0, 0, 8'd0, 0);
    add("tie_req",  13'b1_11_0000_00_0_100, 6'b000001, 0, 0, 8'd0, 0);
    add("tie_hs",   13'b1_11_1100_00_0_100, 6'b000010, 0, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++) add("stall", 13'b1_00_0000_10_0_100, 6'b000010, 0, 0, 8'd0, 0);
    add("tie_b1",   13'b1_00_0000_00_0_100, 6'b000010, 1, 0, 8'd1, 0);
    add("tie_done", 13'b1_00_0000_01_1_100, 6'b010000, 1, 0, 8'd2, 0);
    add("drain_h",  13'b1_00_0000_01_0_100, 6'b010000, 0, 0, 8'd2, 0);
    add("drain_x",  13'b1_00_0000_00_0_100, 6'b000000, 0, 0, 8'd2, 0);

    // Withdraw from REQ, in_done while full_i blocks the beat, Bm chosen when Rt is blocked.
    add("wd_req",   13'b1_10_0000_00_0_000, 6'b000001, 0, 0, 8'd2, 0);
    add("wd_drop",  13'b1_00_0000_00_0_000, 6'b000000, 0, 0, 8'd2, 0);
    add("ed_req",   13'b1_10_0000_00_0_000, 6'b000001, 0, 0, 8'd2, 0);
    add("ed_hs",    13'b1_10_1100_00_0_000, 6'b000010, 0, 0, 8'd2, 0);
    add("ed_done",  13'b1_00_0000_10_1_000, 6'b000000, 0, 0, 8'd2, 0);
    add("blk_bm",   13'b1_11_0000_10_0_000, 6'b000100, 0, 0, 8'd2, 0);
    add("blk_drop", 13'b1_00_0000_00_0_000, 6'b000000, 0, 0, 8'd2, 0);

    // Bm timeout: 16 REQ cycles without rdy2_bm, then ERR clear rules.
    add("tmo_rst",  13'b0_00_0000_00_0_000, 6'b000000, 0, 0, 8'd0, 0);
    add("tmo_req",  13'b1_01_0000_00_0_000, 6'b000100, 0, 0, 8'd0, 0);
    for (int i = 0; i < 15; i++) add("tmo_wait", 13'b1_01_0010_00_0_000, 6'b000100, 0, 0, 8'd0, 0);
    add("tmo_err",  13'b1_01_0010_00_0_000, 6'b100000, 0, 0, 8'd0, 1);
    add("err_want", 13'b1_01_0000_00_0_001, 6'b100000, 0, 0, 8'd0, 1);
    add("err_noclr",13'b1_00_0000_00_0_000, 6'b100000, 0, 0, 8'd0, 1);
    add("err_clr",  13'b1_00_0000_00_0_001, 6'b000000, 0, 0, 8'd0, 0);

    // Five Bm beats (one full_o stall) for the 2-bit wrap, then reset mid-transfer.
    add("wr_rst",   13'b0_00_0000_00_0_000, 6'b000000, 0, 0, 8'd0, 0);
    add("wr_req",   13'b1_01_0000_00_0_000, 6'b000100, 0, 0, 8'd0, 0);
    add("wr_hs",    13'b1_01_0011_00_0_000, 6'b001000, 0, 0, 8'd0, 0);
    add("wr_b1",    13'b1_00_0000_00_0_000, 6'b001000, 0, 1, 8'd1, 0);
    add("wr_b2",    13'b1_00_0000_00_0_000, 6'b001000, 0, 1, 8'd2, 0);
    add("wr_b3",    13'b1_00_0000_00_0_000, 6'b001000, 0, 1, 8'd3, 0);
    add("wr_b4",    13'b1_00_0000_00_0_000, 6'b000000, 0, 1, 8'd4, 0);
    add("wr_req2",  13'b1_01_0000_00_0_000, 6'b000100, 0, 0, 8'd4, 0);
    add("wr_hs2",   13'b1_01_0011_00_0_000, 6'b001000, 0, 0, 8'd4, 0);
    add("wr_stall", 13'b1_00_0000_01_0_000, 6'b001000, 0, 0, 8'd4, 0);
    add("wr_b5",    13'b1_00_0000_00_0_000, 6'b001000, 0, 1, 8'd5, 0);
    add("abort",    13'b0_00_0000_00_0_000, 6'b000000, 0, 0, 8'd0, 0);
    add("post_ab",  13'b1_00_0000_00_0_000, 6'b000000, 0, 0, 8'd0, 0);

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Illegal encoding 000011 must fall back to IDLE with no ack and err untouched.
    @(negedge clk);
    force dut.r_state = 6'b000011;
    #2;
    release dut.r_state;
    @(posedge clk);
    #1;
    chk("illegal.state",  {2'b00, state}, 8'h00);
    chk("illegal.ack_rt", {7'd0, ack_rt}, 8'h00);
    chk("illegal.ack_bm", {7'd0, ack_bm}, 8'h00);
    chk("illegal.err",    {7'd0, err},    8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
